// File: rtl/mem_arb_multi.sv
// N-channel memory request arbiter: round-robin or fixed priority, with an
// in-order tag FIFO routing read data back to the channel that issued it.
module mem_arb_multi #(
    parameter int CHANNELS = 3,
    parameter int ADDRESS  = 21,
    parameter int WIDTH    = 32,
    parameter int RDEPTH   = 4,
    parameter int FIXEDPRI = 0,
    localparam int BES     = WIDTH / 8
) (
    input  logic                        mem_clk_i,
    input  logic                        reset_ni,
    input  logic [CHANNELS-1:0]         ch_read_i,
    input  logic [CHANNELS-1:0]         ch_write_i,
    input  logic [CHANNELS*ADDRESS-1:0] ch_addr_i,
    input  logic [CHANNELS*BES-1:0]     ch_bes_ni,
    input  logic [CHANNELS*WIDTH-1:0]   ch_data_i,
    output logic [CHANNELS-1:0]         ch_rack_o,
    output logic [CHANNELS-1:0]         ch_wack_o,
    output logic [CHANNELS-1:0]         ch_ready_o,
    output logic [WIDTH-1:0]            ch_data_o,
    output logic                        busy_o,
    output logic                        mem_read_o,
    output logic                        mem_write_o,
    input  logic                        mem_ack_i,
    input  logic                        mem_ready_i,
    output logic [ADDRESS-1:0]          mem_addr_o,
    output logic [BES-1:0]              mem_bes_no,
    output logic [WIDTH-1:0]            mem_data_o,
    input  logic [WIDTH-1:0]            mem_data_i
);
    localparam int CW = $clog2(CHANNELS);
    localparam int PW = $clog2(RDEPTH);
    localparam int NW = PW + 1;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t state, state_nxt;

    logic [CHANNELS-1:0][ADDRESS-1:0] addr_a;
    logic [CHANNELS-1:0][BES-1:0]     bes_a;
    logic [CHANNELS-1:0][WIDTH-1:0]   data_a;

    logic [CW-1:0]             last_grant, cur_ch, pick, cand;
    logic                      found, grant, done, full, take_rd, push, pop;
    logic [CHANNELS-1:0]       elig;
    logic [RDEPTH-1:0][CW-1:0] tags;
    logic [PW-1:0]             wptr, rptr;
    logic [NW-1:0]             count;

    function automatic logic [CHANNELS-1:0] onehot(input logic [CW-1:0] c);
        logic [CHANNELS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    assign addr_a = ch_addr_i;
    assign bes_a  = ch_bes_ni;
    assign data_a = ch_data_i;

    // Reads are only eligible while a tag slot is free; writes always are.
    assign full    = (count == NW'(RDEPTH));
    assign elig    = ch_write_i | (ch_read_i & {CHANNELS{~full}});
    assign take_rd = ch_read_i[pick] & ~full;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (FIXEDPRI != 0) cand = CW'(i);
            else               cand = CW'((int'(last_grant) + 1 + i) % CHANNELS);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge mem_clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (found) begin
                grant     = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: if (mem_ack_i) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_bes_no  <= '0;
            mem_data_o  <= '0;
            cur_ch      <= '0;
            last_grant  <= CW'(CHANNELS - 1);
        end else if (grant) begin
            mem_read_o  <= take_rd;
            mem_write_o <= ~take_rd;
            mem_addr_o  <= addr_a[pick];
            mem_bes_no  <= bes_a[pick];
            mem_data_o  <= data_a[pick];
            cur_ch      <= pick;
        end else if (done) begin
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            last_grant  <= cur_ch;
        end
    end

    assign ch_rack_o = (done && mem_read_o)  ? onehot(cur_ch) : '0;
    assign ch_wack_o = (done && mem_write_o) ? onehot(cur_ch) : '0;

    // Read data returns in issue order, so the FIFO head names its owner.
    assign push = done & mem_read_o;
    assign pop  = mem_ready_i & (count != '0);

    always_ff @(posedge mem_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tags       <= '0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            ch_ready_o <= '0;
            ch_data_o  <= '0;
        end else begin
            if (push) begin
                tags[wptr] <= cur_ch;
                wptr       <= wptr + PW'(1);
            end
            if (pop) begin
                rptr      <= rptr + PW'(1);
                ch_data_o <= mem_data_i;
            end
            ch_ready_o <= pop ? onehot(tags[rptr]) : '0;
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    assign busy_o = (state == ISSUE) | (count != '0);

endmodule

// File: doc/mem_arb_multi.md
# mem_arb_multi

Parametrised N-channel memory-request arbiter for the memory controller front end. It replaces the fixed two-client (PCI + video) arbitration with CHANNELS clients and selectable round-robin or fixed priority. It tracks up to RDEPTH outstanding reads so returned read data reaches the channel that issued it. It sits between the client blocks (PCI target, video fetch, CPU tile) and the SDRAM command/data path, all on the memory clock.

## Interface
- CHANNELS, 3: number of client channels (2–8); channel index = bit position.
- ADDRESS, 21: word-address width.
- WIDTH, 32: data width; byte enables are WIDTH/8 bits, written BES below.
- RDEPTH, 4: maximum outstanding reads (power of two, ≥2).
- FIXEDPRI, 0: 0 = round-robin; 1 = fixed priority, channel 0 highest.

Ports:
- mem_clk_i  in  1  memory clock; the only clock.
- reset_ni  in  1  asynchronous, active-low reset.
- ch_read_i  in  CHANNELS  per-channel read request, held until rack.
- ch_write_i  in  CHANNELS  per-channel write request, held until wack.
- ch_addr_i  in  CHANNELS*ADDRESS  packed addresses, channel 0 in LSBs.
- ch_bes_ni  in  CHANNELS*BES  packed active-low byte enables.
- ch_data_i  in  CHANNELS*WIDTH  packed write data.
- ch_rack_o  out  CHANNELS  read accepted, one-cycle pulse.
- ch_wack_o  out  CHANNELS  write accepted, one-cycle pulse.
- ch_ready_o  out  CHANNELS  read data valid for that channel, one-cycle pulse.
- ch_data_o  out  WIDTH  read data, broadcast to all channels.
- busy_o  out  1  transaction issuing or reads outstanding.
- mem_read_o, mem_write_o  out  1  command to the memory core, held until mem_ack_i.
- mem_ack_i  in  1  command accepted.
- mem_ready_i  in  1  read data valid; returns in issue order.
- mem_addr_o  out  ADDRESS; mem_bes_no  out  BES; mem_data_o  out  WIDTH: registered command fields.
- mem_data_i  in  WIDTH  read data.

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: the channel is eligible if ch_write_i is set, or if ch_read_i is set and the tag FIFO is not full.
  - Round-robin mode: search starts at last_grant+1 and wraps modulo CHANNELS.
  - Fixed-priority mode: lowest eligible index wins.
  - On a grant: register the channel's addr, bes, data, read/write and channel id. Go to ISSUE.
- A channel asserting both read and write is issued as a read. Its write stays pending.
- ISSUE: hold mem_read_o or mem_write_o and the fields stable until mem_ack_i. On the ack cycle:
  - pulse ch_rack_o or ch_wack_o of the granted channel, combinationally from mem_ack_i;
  - push the channel id into the tag FIFO if the command is a read;
  - update last_grant;
  - return to IDLE.
- Tag FIFO: RDEPTH entries with a count register.
  - On mem_ready_i: pop the head; pulse ch_ready_o[head] for one cycle; drive ch_data_o = mem_data_i, registered.
  - A push and a pop in the same cycle leave the count unchanged.
- mem_ready_i while the FIFO is empty is ignored: no ch_ready_o, pointers unchanged.
- busy_o = (state == ISSUE) | (count != 0).

## Timing
- Reset values: state IDLE; last_grant = CHANNELS-1, so channel 0 is checked first. All ch_*_o, mem_read_o, mem_write_o and busy_o are 0. mem_addr_o, mem_bes_no and mem_data_o are 0. Tag FIFO is empty.
- Reset during ISSUE or with reads outstanding: the command drops immediately (asynchronous). Pending tags are discarded, and late mem_ready_i after reset is ignored.
- Request→command latency: a request sampled in IDLE at edge n gives mem_*_o high after edge n.
- After an ack, the FSM spends one IDLE cycle before the next command. Peak rate is one command per 2 cycles with zero-wait ack.
- Clients must drop the request at the edge following the rack/wack pulse, or they are re-granted.
- Read data latency: ch_ready_o and ch_data_o assert one cycle after mem_ready_i.
- With RDEPTH reads outstanding, reads are not granted, but writes still are. After a pop, a read is grantable in the following IDLE cycle.

## Test plan
- Single read, ch1: ch_read_i=010, addr 0x00123, mem_ack_i after 2 cycles, mem_ready_i with data 0xDEADBEEF 5 cycles later. Expect mem_addr_o=0x00123, ch_rack_o=010 for 1 cycle, then ch_ready_o=010 with ch_data_o=0xDEADBEEF; busy_o drops afterward.
- Round-robin, all three channels holding read requests, zero-wait ack. Expect grant order 0,1,2,0. With FIXEDPRI=1, channel 0 is granted each time until it drops.
- Outstanding limit, RDEPTH=4: ch0 issues 5 reads with no mem_ready_i. Expect exactly 4 racks, with the 5th held. A ch2 write meanwhile gets wack. One mem_ready_i then lets the 5th read issue.
- Ordering: ch2 read then ch0 read, data 0x11 then 0x22. Expect ch_ready_o=100 with 0x11, then 001 with 0x22.
- Reset asserted while ISSUE is waiting for ack with 2 tags outstanding. Expect all outputs 0 immediately. After release, a stray mem_ready_i produces no ch_ready_o.
- Read+write on ch1 simultaneously with bes_n=0x0: read issued first, then the write with mem_bes_no=0x0 and mem_data_o equal to ch1's data.
